mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N_CH:1 word multiplexer for WIDTH-bit channels.
- Built as a tree of radix-4 levels with a radix-2 final level when log2(N_CH) is odd. A register follows every level.
- Adds a valid pipeline, a channel tag on the output, and an auto-scan mode that steps through channels with a programmable dwell.
- Sits between the multi-source capture logic and single-lane consumers (display, serialiser). Replaces the fixed 8:1 combinational mux.

---
 rtl/mux_tree_pkg.sv | 21 ++
 rtl/mux4_stage.sv | 50 +++++
 rtl/mux_tree_pipe.sv | 101 ++++++++++
 tb/tb_mux_tree_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared definitions for the pipelined multiplexer tree: level count helper
// and channel-index sizing.
package mux_tree_pkg;

    localparam int MAX_CH = 64;
    localparam int MAX_SW = $clog2(MAX_CH);

    // Widest channel index any instance can carry; modules narrow it to SW.
    typedef logic [MAX_SW-1:0] ch_idx_t;

    // Number of registered tree levels: radix-4 levels plus one radix-2 level
    // when log2(n) is odd.
    function automatic int levels(input int n);
        int sw;
        sw = 0;
        while ((1 << sw) < n)
            sw++;
        return (sw + 1) / 2;
    endfunction

endpackage

// File: rtl/mux4_stage.sv
// One registered level of the mux tree: N_IN/RADIX parallel RADIX:1 muxes,
// steered by a slice of the travelling channel tag.
module mux4_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int RADIX = 4,
    parameter int SW    = 2,
    parameter int SHIFT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_IN-1:0][WIDTH-1:0]       in_data,
    input  logic [SW-1:0]                    in_tag,
    input  logic                             in_valid,
    output logic [N_IN/RADIX-1:0][WIDTH-1:0] out_data,
    output logic [SW-1:0]                    out_tag,
    output logic                             out_valid
);

    localparam int N_OUT = N_IN / RADIX;
    localparam int RB    = (RADIX == 4) ? 2 : 1;

    logic [N_OUT-1:0][RADIX-1:0][WIDTH-1:0] grp;
    logic [N_OUT-1:0][WIDTH-1:0]            nxt;
    logic [RB-1:0]                          lsel;

    // Regroup the flat input so each output mux sees its own RADIX inputs.
    assign grp  = in_data;
    assign lsel = in_tag[SHIFT +: RB];

    for (genvar j = 0; j < N_OUT; j++) begin : lane
        assign nxt[j] = grp[j][lsel];
    end

    // The full tag rides along so later levels can pick their own select bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= nxt;
            out_tag   <= in_tag;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_CH:1 word multiplexer with per-beat select, valid/tag pipeline
// and an auto-scan mode that dwells DWELL valid beats on each channel.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 8,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic [SW-1:0]           sel,
    input  logic                    scan_en,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SW-1:0]           out_ch
);

    localparam int L  = levels(N_CH);
    localparam int DW = $clog2(DWELL + 1);

    typedef logic [SW-1:0] ch_t;

    ch_t                        scan_ch;
    ch_t                        esel;
    logic [DW-1:0]              dwell_cnt;
    logic [L:0]                 vld_pipe;
    logic [N_CH-1:0][WIDTH-1:0] din;

    assign din         = in_data;
    assign esel        = scan_en ? scan_ch : sel;
    assign vld_pipe[0] = in_valid;

    // Only accepted beats count toward the dwell; dropping scan_en freezes
    // the position so scanning resumes exactly where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ch   <= '0;
            dwell_cnt <= '0;
        end else if (scan_en && in_valid) begin
            if (dwell_cnt == DW'(DWELL - 1)) begin
                dwell_cnt <= '0;
                scan_ch   <= scan_ch + ch_t'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    for (genvar g = 0; g < L; g++) begin : lvl
        localparam int NI = N_CH >> (2 * g);
        localparam int R  = (SW - 2 * g >= 2) ? 4 : 2;

        logic [NI/R-1:0][WIDTH-1:0] d;
        ch_t                        tag;

        if (g == 0) begin : src
            mux4_stage #(
                .WIDTH (WIDTH),
                .N_IN  (NI),
                .RADIX (R),
                .SW    (SW),
                .SHIFT (0)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_data   (din),
                .in_tag    (esel),
                .in_valid  (vld_pipe[0]),
                .out_data  (d),
                .out_tag   (tag),
                .out_valid (vld_pipe[1])
            );
        end else begin : src
            mux4_stage #(
                .WIDTH (WIDTH),
                .N_IN  (NI),
                .RADIX (R),
                .SW    (SW),
                .SHIFT (2 * g)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_data   (lvl[g-1].d),
                .in_tag    (lvl[g-1].tag),
                .in_valid  (vld_pipe[g]),
                .out_data  (d),
                .out_tag   (tag),
                .out_valid (vld_pipe[g+1])
            );
        end
    end

    assign out_data  = lvl[L-1].d[0];
    assign out_ch    = lvl[L-1].tag;
    assign out_valid = vld_pipe[L];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Randomised bench for mux_tree_pipe across several parameter sets, checked
// against a per-beat queue model of channel selection and scan dwell.
module tb_mux_tree_pipe;

    logic clk;
    int   checks;
    int   failures;
    int   ndone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_n(input int k);
        case (k) 0: return 8; 1: return 2; 2: return 4; 3: return 16; default: return 32; endcase
    endfunction
    function automatic int cfg_w(input int k);
        case (k) 0: return 8; 1: return 1; 2: return 16; 3: return 16; default: return 1; endcase
    endfunction
    function automatic int cfg_d(input int k);
        case (k) 0: return 4; 1: return 1; 2: return 2; 3: return 3; default: return 1; endcase
    endfunction
    function automatic int cfg_lat(input int k);
        case (k) 0: return 2; 1: return 1; 2: return 1; 3: return 2; default: return 3; endcase
    endfunction

    for (genvar k = 0; k < 5; k++) begin : g_cfg
        localparam int N   = cfg_n(k);
        localparam int W   = cfg_w(k);
        localparam int D   = cfg_d(k);
        localparam int LAT = cfg_lat(k);
        localparam int SW  = $clog2(N);

        logic           rst, vin, sen, vout;
        logic [N*W-1:0] din;
        logic [SW-1:0]  sel, och;
        logic [W-1:0]   dout;

        typedef struct {
            bit           v;
            logic [W-1:0] d;
            int           ch;
        } exp_t;

        exp_t q[$];
        int   beats;
        int   lat;

        mux_tree_pipe #(.WIDTH(W), .N_CH(N), .DWELL(D)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (din),
            .in_valid  (vin),
            .sel       (sel),
            .scan_en   (sen),
            .out_data  (dout),
            .out_valid (vout),
            .out_ch    (och)
        );

        function automatic string tg(input string s);
            return $sformatf("c%0d_%s", k, s);
        endfunction

        task automatic rnd_din();
            for (int c = 0; c < N; c++)
                din[c*W +: W] = W'($urandom);
        endtask

        // Scan position is simply the count of accepted scan beats / DWELL.
        task automatic step();
            exp_t e;
            int   es;
            es   = sen ? (beats / D) % N : int'(sel);
            e.v  = vin;
            e.ch = es;
            e.d  = din[es*W +: W];
            if (sen && vin)
                beats++;
            q.push_back(e);
            @(posedge clk);
            #1;
            if (q.size() == LAT) begin
                e = q.pop_front();
                chk(tg("valid"), 64'(vout), 64'(e.v));
                if (e.v) begin
                    chk(tg("data"), 64'(dout), 64'(e.d));
                    chk(tg("ch"), 64'(och), 64'(e.ch));
                end
            end else begin
                chk(tg("bubble"), 64'(vout), 64'(0));
            end
        endtask

        initial begin
            rst = 1'b1; vin = 1'b0; sen = 1'b0; sel = '0; din = '0; beats = 0;
            repeat (3) @(posedge clk);
            #1;
            chk(tg("rst_data"), 64'(dout), 64'(0));
            chk(tg("rst_valid"), 64'(vout), 64'(0));
            chk(tg("rst_ch"), 64'(och), 64'(0));
            @(negedge clk) rst = 1'b0;

            // latency probe: one valid beat, count edges until it emerges
            vin = 1'b1;
            lat = 0;
            for (int n = 1; n <= 8; n++) begin
                @(posedge clk);
                #1;
                vin = 1'b0;
                if (vout && lat == 0)
                    lat = n;
            end
            chk(tg("latency"), 64'(lat), 64'(LAT));

            // manual sweep with fixed channel words
            for (int c = 0; c < N; c++)
                din[c*W +: W] = W'(16 + c);
            for (int c = 0; c < N; c++) begin
                sel = SW'(c); vin = 1'b1; step();
            end

            // alternating select with data changing every beat
            for (int i = 0; i < 16; i++) begin
                rnd_din();
                sel = (i % 2 == 1) ? SW'(5 % N) : SW'(3 % N);
                step();
            end

            // continuous scan through a full wrap
            sen = 1'b1;
            for (int i = 0; i < N * D + 3; i++) begin
                rnd_din(); sel = SW'($urandom); step();
            end

            // asynchronous reset with words in flight
            rnd_din(); step();
            rnd_din(); step();
            #2 rst = 1'b1;
            #1;
            chk(tg("arst_data"), 64'(dout), 64'(0));
            chk(tg("arst_valid"), 64'(vout), 64'(0));
            chk(tg("arst_ch"), 64'(och), 64'(0));
            @(posedge clk);
            @(negedge clk) rst = 1'b0;
            q.delete();
            beats = 0;

            // scan with input gaps, then a pause and resume
            for (int i = 0; i < 8; i++) begin
                rnd_din(); vin = !(i == 2 || i == 3); step();
            end
            sen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                rnd_din(); vin = 1'b1; sel = SW'($urandom); step();
            end
            sen = 1'b1;
            for (int i = 0; i < 2 * D + 2; i++) begin
                rnd_din(); step();
            end

            // random mix of select, scan and valid
            for (int i = 0; i < 300; i++) begin
                rnd_din();
                vin = ($urandom_range(3) != 0);
                sen = ($urandom_range(2) == 0);
                sel = SW'($urandom);
                step();
            end

            vin = 1'b0;
            repeat (LAT) step();
            ndone++;
        end
    end

    initial begin
        checks = 0; failures = 0; ndone = 0;
        wait (ndone == 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout done=%0d required=5", ndone);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
